// File: rtl/frame_pkg.sv
// frame_pkg: frame geometry and fill FSM encoding shared by the frame-buffer blocks.
package frame_pkg;
   localparam int FB_AW    = 15;
   localparam int FB_DW    = 12;
   localparam int FB_H_RES = 160;
   localparam int FB_V_RES = 120;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_DONE = 2'd2
   } fill_state_t;
endpackage

// File: rtl/fill_addr_gen.sv
// fill_addr_gen: raster x/y walker over a clipped rectangle with an incremental row base.
module fill_addr_gen
   import frame_pkg::*;
#(
   parameter int AW    = FB_AW,
   parameter int H_RES = FB_H_RES
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic          step,
   input  logic [7:0]    x0,
   input  logic [7:0]    y0,
   input  logic [8:0]    x_end,
   input  logic [8:0]    y_end,
   output logic [AW-1:0] addr,
   output logic          last
);
   logic [8:0]    x, y, x_start, x_stop, y_stop;
   logic [AW-1:0] row_base, base0;
   logic          x_last;
   // starting row base y0*H_RES as a shift-add over the bits of y0
   always_comb begin
      base0 = '0;
      for (int i = 0; i < 8; i++)
         if (y0[i]) base0 = base0 + (AW'(H_RES) << i);
   end
   assign x_last = (x + 9'd1) == x_stop;
   assign last   = x_last && ((y + 9'd1) == y_stop);
   assign addr   = row_base + AW'(x);
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         x        <= '0;
         y        <= '0;
         x_start  <= '0;
         x_stop   <= '0;
         y_stop   <= '0;
         row_base <= '0;
      end else if (load) begin
         x        <= {1'b0, x0};
         y        <= {1'b0, y0};
         x_start  <= {1'b0, x0};
         x_stop   <= x_end;
         y_stop   <= y_end;
         row_base <= base0;
      end else if (step) begin
         if (x_last) begin
            x        <= x_start;
            y        <= y + 9'd1;
            row_base <= row_base + AW'(H_RES);
         end else begin
            x <= x + 9'd1;
         end
      end
endmodule

// File: rtl/frame_fill_writer.sv
// frame_fill_writer: fills a clipped rectangle (or the whole frame) of the frame buffer,
// one pixel per cycle in raster order.
module frame_fill_writer
   import frame_pkg::*;
#(
   parameter int AW    = FB_AW,
   parameter int DW    = FB_DW,
   parameter int H_RES = FB_H_RES,
   parameter int V_RES = FB_V_RES
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [7:0]    cmd_x0,
   input  logic [7:0]    cmd_y0,
   input  logic [7:0]    cmd_w,
   input  logic [7:0]    cmd_h,
   input  logic [DW-1:0] cmd_color,
   input  logic          clear_req,
   output logic [AW-1:0] addr_in,
   output logic [DW-1:0] data_in,
   output logic          regwrite,
   output logic          busy,
   output logic          done
);
   fill_state_t   state, state_n;
   logic          armed, accept, degenerate, last;
   logic [DW-1:0] color;
   logic [AW-1:0] addr;
   logic [8:0]    x_sum, y_sum, x_end, y_end;
   logic [7:0]    ld_x0, ld_y0;
   // 9-bit sums so x0+w cannot wrap before clipping
   assign x_sum      = {1'b0, cmd_x0} + {1'b0, cmd_w};
   assign y_sum      = {1'b0, cmd_y0} + {1'b0, cmd_h};
   assign ld_x0      = clear_req ? 8'd0 : cmd_x0;
   assign ld_y0      = clear_req ? 8'd0 : cmd_y0;
   assign x_end      = clear_req ? 9'(H_RES) : (x_sum > 9'(H_RES) ? 9'(H_RES) : x_sum);
   assign y_end      = clear_req ? 9'(V_RES) : (y_sum > 9'(V_RES) ? 9'(V_RES) : y_sum);
   assign degenerate = !clear_req && (cmd_w == 8'd0 || cmd_h == 8'd0 ||
                       {1'b0, cmd_x0} >= 9'(H_RES) || {1'b0, cmd_y0} >= 9'(V_RES));
   assign accept     = cmd_ready && (cmd_valid || clear_req);
   fill_addr_gen #(.AW(AW), .H_RES(H_RES)) u_addr (
      .clk   (clk),
      .reset (reset),
      .load  (accept),
      .step  (state == ST_FILL),
      .x0    (ld_x0),
      .y0    (ld_y0),
      .x_end (x_end),
      .y_end (y_end),
      .addr  (addr),
      .last  (last)
   );
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state <= ST_IDLE;
         armed <= 1'b0;
         color <= '0;
      end else begin
         state <= state_n;
         armed <= 1'b1;
         if (accept) color <= cmd_color;
      end
   always_comb begin
      state_n   = state;
      state_n   = (state == ST_IDLE) ? (accept ? (degenerate ? ST_DONE : ST_FILL) : ST_IDLE) :
                  (state == ST_FILL) ? (last ? ST_DONE : ST_FILL) : ST_IDLE;
      cmd_ready = armed && state == ST_IDLE;
      regwrite  = state == ST_FILL;
      busy      = state != ST_IDLE;
      done      = state == ST_DONE;
      addr_in   = regwrite ? addr : '0;
      data_in   = regwrite ? color : '0;
   end
endmodule
